// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Helpers shared by the width-converting synchronous FIFOs (upsizing
//   sync_fifo_ps and its downsizing counterpart).
//   - calc_sp_cnt : number of narrow words per wide word.
//   - safe_clog2  : ceil(log2(n)), never less than 1, so counters stay >= 1 bit.
//   - params_ok   : elaboration-time legality of a width/depth combination.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  function automatic int calc_sp_cnt(input int wide_width, input int narrow_width);
    return wide_width / narrow_width;
  endfunction

  function automatic int safe_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Wide width must be an exact multiple (>= 2x) of the narrow width and the
  // memory must hold at least two wide entries.
  function automatic bit params_ok(input int narrow_width, input int wide_width,
                                   input int depth);
    return (narrow_width > 0) && (wide_width % narrow_width == 0) &&
           (wide_width / narrow_width >= 2) && (depth >= 2);
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ps_packer.sv
// -----------------------------------------------------------------------------
// sync_fifo_ps_packer
//   Gathers SP_CNT narrow words into one wide word. Lane k holds the k-th
//   narrow word of the current group at bits [k*W_WIDTH +: W_WIDTH].
//   The commit pulse and data are combinational so the assembled word can be
//   written to memory on the same edge as the write that completes it.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   wr_accept    : narrow write accepted this cycle (already gated by wfull)
//   din          : narrow write data
//   flush_req    : request to commit a partial word (already gated by
//                  memory-full); ignored while the packer is empty
//   pack_cnt     : number of lanes currently filled
//   commit       : a wide word is handed to memory on this edge
//   commit_data  : wide word to store when commit is high
// -----------------------------------------------------------------------------
module sync_fifo_ps_packer
  import sync_fifo_pkg::*;
#(
  parameter int W_WIDTH = 8,
  parameter int SP_CNT  = 4,
  parameter int CNT_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_accept,
  input  logic [W_WIDTH-1:0]          din,
  input  logic                        flush_req,
  output logic [CNT_W-1:0]            pack_cnt,
  output logic                        commit,
  output logic [W_WIDTH*SP_CNT-1:0]   commit_data
);

  localparam int R_WIDTH = W_WIDTH * SP_CNT;

  logic [R_WIDTH-1:0] lanes_q, lanes_d;
  logic [R_WIDTH-1:0] merged;
  logic [CNT_W-1:0]   pack_cnt_q, pack_cnt_d;
  logic               last_lane;
  logic               flush_go;

  // Lanes are cleared on every commit, so lanes above pack_cnt are always
  // zero and a flushed word comes out zero-padded without extra masking.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    merged      = lanes_q;
    lanes_d     = lanes_q;
    pack_cnt_d  = pack_cnt_q;
    last_lane   = (pack_cnt_q == CNT_W'(SP_CNT - 1));
    flush_go    = flush_req && (pack_cnt_q != '0);

    for (int k = 0; k < SP_CNT; k++) begin
      if (wr_accept && (pack_cnt_q == CNT_W'(k))) begin
        merged[k*W_WIDTH +: W_WIDTH] = din;
      end
    end

    // A write that completes the word and a flush on the same edge produce
    // exactly one commit of the completed word.
    commit      = (wr_accept && last_lane) || flush_go;
    commit_data = merged;

    if (commit) begin
      lanes_d    = '0;
      pack_cnt_d = '0;
    end else if (wr_accept) begin
      lanes_d    = merged;
      pack_cnt_d = pack_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q    <= '0;
      pack_cnt_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  assign pack_cnt = pack_cnt_q;

endmodule : sync_fifo_ps_packer

// File: rtl/sync_fifo_ps.sv
// -----------------------------------------------------------------------------
// sync_fifo_ps
//   Single-clock upsizing FIFO: narrow words are packed (first word in the
//   LSBs) into R_WIDTH-bit words stored in a DEPTH-entry memory and read out
//   whole. DEPTH need not be a power of two; pointers wrap explicitly.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : (only with SYNC_FIFO_PS_FLUSH_EN) commit a partial word,
//                 unfilled lanes zeroed
//   wr_en, din  : narrow write request / data
//   rd_en       : wide read request
//   dout        : registered wide read data, holds between reads
//   dout_valid  : one-cycle pulse when dout was updated
//   wfull       : the next narrow write would be refused
//   rempty      : no complete wide word stored
//   fifo_cnt    : number of stored wide words
//   pack_cnt    : number of narrow words waiting in the packer
//
// Build option
//   SYNC_FIFO_PS_FLUSH_EN : adds the flush input.
// -----------------------------------------------------------------------------
module sync_fifo_ps
  import sync_fifo_pkg::*;
#(
  parameter  int W_WIDTH = 8,
  parameter  int R_WIDTH = 32,
  parameter  int DEPTH   = 16,
  localparam int SP_CNT  = calc_sp_cnt(R_WIDTH, W_WIDTH),
  localparam int PACK_W  = safe_clog2(SP_CNT),
  localparam int FCNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SYNC_FIFO_PS_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               wr_en,
  input  logic [W_WIDTH-1:0] din,
  input  logic               rd_en,
  output logic [R_WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               wfull,
  output logic               rempty,
  output logic [FCNT_W-1:0]  fifo_cnt,
  output logic [PACK_W-1:0]  pack_cnt
);

  localparam int PTR_W = safe_clog2(DEPTH);

  if (!params_ok(W_WIDTH, R_WIDTH, DEPTH)) begin : g_bad_params
    $error("sync_fifo_ps: R_WIDTH must be a multiple (>=2x) of W_WIDTH and DEPTH >= 2");
  end

  logic [R_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]   w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0]   r_ptr_q, r_ptr_d;
  logic [FCNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [R_WIDTH-1:0] dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;

  logic               mem_full;
  logic               wr_accept;
  logic               rd_accept;
  logic               flush_req;
  logic               commit;
  logic [R_WIDTH-1:0] commit_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flags come from registered state only: a read on this edge does not
  // free space for a write on the same edge.
  assign mem_full  = (fifo_cnt_q == FCNT_W'(DEPTH));
  assign wfull     = mem_full && (pack_cnt == PACK_W'(SP_CNT - 1));
  assign rempty    = (fifo_cnt_q == '0);
  assign wr_accept = wr_en && !wfull;
  assign rd_accept = rd_en && !rempty;

`ifdef SYNC_FIFO_PS_FLUSH_EN
  assign flush_req = flush && !mem_full;
`else
  assign flush_req = 1'b0;
`endif

  sync_fifo_ps_packer #(
    .W_WIDTH (W_WIDTH),
    .SP_CNT  (SP_CNT),
    .CNT_W   (PACK_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .wr_accept   (wr_accept),
    .din         (din),
    .flush_req   (flush_req),
    .pack_cnt    (pack_cnt),
    .commit      (commit),
    .commit_data (commit_data)
  );

  // A commit can never happen while memory is full: the completing write is
  // refused by wfull and flush is gated by mem_full.
  always_comb begin
    w_ptr_d      = w_ptr_q;
    r_ptr_d      = r_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = rd_accept;

    if (commit) w_ptr_d = ptr_inc(w_ptr_q);
    if (rd_accept) begin
      r_ptr_d = ptr_inc(r_ptr_q);
      dout_d  = mem_q[r_ptr_q];
    end

    case ({commit, rd_accept})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q      <= '0;
      r_ptr_q      <= '0;
      fifo_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      w_ptr_q      <= w_ptr_d;
      r_ptr_q      <= r_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // NOTE: the storage array has no reset; clearing pointers and count is
  // enough to discard its contents and keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (commit) mem_q[w_ptr_q] <= commit_data;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign fifo_cnt   = fifo_cnt_q;

endmodule : sync_fifo_ps
